arcade_input_ctrl: RTL



---
 rtl/arcade_input_pkg.sv | 82 ++++++++
 rtl/coin_pulse.sv | 76 +++++++
 rtl/arcade_input_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input front-end.
package arcade_input_pkg;

    // 9-bit key codes: {extended, scan code}
    localparam logic [8:0] KEY_UP       = 9'h175;
    localparam logic [8:0] KEY_DOWN     = 9'h172;
    localparam logic [8:0] KEY_LEFT     = 9'h16B;
    localparam logic [8:0] KEY_RIGHT    = 9'h174;
    localparam logic [8:0] KEY_FIRE_A   = 9'h029;
    localparam logic [8:0] KEY_FIRE_B   = 9'h014;
    localparam logic [8:0] KEY_START1_A = 9'h005;
    localparam logic [8:0] KEY_START1_B = 9'h016;
    localparam logic [8:0] KEY_START2_A = 9'h006;
    localparam logic [8:0] KEY_START2_B = 9'h01E;
    localparam logic [8:0] KEY_COIN1    = 9'h02E;
    localparam logic [8:0] KEY_COIN2    = 9'h036;
    localparam logic [8:0] KEY_P2_UP    = 9'h02D;
    localparam logic [8:0] KEY_P2_DOWN  = 9'h02B;
    localparam logic [8:0] KEY_P2_LEFT  = 9'h023;
    localparam logic [8:0] KEY_P2_RIGHT = 9'h034;
    localparam logic [8:0] KEY_P2_FIRE  = 9'h01C;
    localparam logic [8:0] KEY_TEST     = 9'h02C;

    // Slot of each key in the latch vector
    localparam int unsigned K_UP       = 0;
    localparam int unsigned K_DOWN     = 1;
    localparam int unsigned K_LEFT     = 2;
    localparam int unsigned K_RIGHT    = 3;
    localparam int unsigned K_FIRE_A   = 4;
    localparam int unsigned K_FIRE_B   = 5;
    localparam int unsigned K_START1_A = 6;
    localparam int unsigned K_START1_B = 7;
    localparam int unsigned K_START2_A = 8;
    localparam int unsigned K_START2_B = 9;
    localparam int unsigned K_COIN1    = 10;
    localparam int unsigned K_COIN2    = 11;
    localparam int unsigned K_P2_UP    = 12;
    localparam int unsigned K_P2_DOWN  = 13;
    localparam int unsigned K_P2_LEFT  = 14;
    localparam int unsigned K_P2_RIGHT = 15;
    localparam int unsigned K_P2_FIRE  = 16;
    localparam int unsigned K_TEST     = 17;
    localparam int unsigned NUM_KEYS   = 18;

    // Joystick word bit positions
    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_REL
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dirs_t;

    // Cabinet is vertical; in horizontal mode the stick is turned a quarter.
    function automatic dirs_t orient(input dirs_t raw, input logic rotate);
        dirs_t res;
        if (rotate) begin
            res.up    = raw.left;
            res.down  = raw.right;
            res.left  = raw.down;
            res.right = raw.up;
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/coin_pulse.sv
// Converts a level coin request into one fixed-width pulse per press,
// followed by an enforced low gap and a wait for the request to drop.
module coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 600000,
    parameter int unsigned GAP_CYCLES   = 1200000,
    parameter int unsigned CNT_W        = 21
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic req,
    output logic pulse
);

    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_CYCLES - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    // Next-state and timer update
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = PULSE;
                    timer_d = '0;
                end
            end
            PULSE: begin
                if (timer_q == PulseLast) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (timer_q == GapLast) begin
                    state_d = WAIT_REL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                // A held request must be released before the next coin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State and timer registers
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Decoded from the state register so reset drops it immediately
    assign pulse = (state_q == PULSE);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick front-end for the Amidar core: key latching, orientation
// remap, registered player inputs and rate-limited coin pulses.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYCLES = 600000,
    parameter int unsigned COIN_GAP_CYCLES   = 1200000,
    parameter int unsigned CNT_W             = 21
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic [6:0]  ip_1p,
    output logic [6:0]  ip_2p,
    output logic        ip_coin1,
    output logic        ip_coin2,
    output logic        btn_test
);

    logic                old_tog_q;
    logic                key_event;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [15:0]         joy;
    logic                unused_joy;

    dirs_t raw_1p, raw_2p, dir_1p, dir_2p;
    logic  fire_1p, fire_2p, start_1p, start_2p;
    logic  req1, req2;

    logic [6:0] ip_1p_d, ip_1p_q;
    logic [6:0] ip_2p_d, ip_2p_q;
    logic       btn_test_q;

    assign key_event = (ps2_key[10] != old_tog_q);

    // Load the latch addressed by the event's code with its pressed flag
    always_comb begin
        keys_d = keys_q;
        if (key_event) begin
            case (ps2_key[8:0])
                KEY_UP:       keys_d[K_UP]       = ps2_key[9];
                KEY_DOWN:     keys_d[K_DOWN]     = ps2_key[9];
                KEY_LEFT:     keys_d[K_LEFT]     = ps2_key[9];
                KEY_RIGHT:    keys_d[K_RIGHT]    = ps2_key[9];
                KEY_FIRE_A:   keys_d[K_FIRE_A]   = ps2_key[9];
                KEY_FIRE_B:   keys_d[K_FIRE_B]   = ps2_key[9];
                KEY_START1_A: keys_d[K_START1_A] = ps2_key[9];
                KEY_START1_B: keys_d[K_START1_B] = ps2_key[9];
                KEY_START2_A: keys_d[K_START2_A] = ps2_key[9];
                KEY_START2_B: keys_d[K_START2_B] = ps2_key[9];
                KEY_COIN1:    keys_d[K_COIN1]    = ps2_key[9];
                KEY_COIN2:    keys_d[K_COIN2]    = ps2_key[9];
                KEY_P2_UP:    keys_d[K_P2_UP]    = ps2_key[9];
                KEY_P2_DOWN:  keys_d[K_P2_DOWN]  = ps2_key[9];
                KEY_P2_LEFT:  keys_d[K_P2_LEFT]  = ps2_key[9];
                KEY_P2_RIGHT: keys_d[K_P2_RIGHT] = ps2_key[9];
                KEY_P2_FIRE:  keys_d[K_P2_FIRE]  = ps2_key[9];
                KEY_TEST:     keys_d[K_TEST]     = ps2_key[9];
                default:      ;
            endcase
        end
    end

    // Toggle tracker and key latches
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            old_tog_q <= 1'b0;
            keys_q    <= '0;
        end else begin
            old_tog_q <= ps2_key[10];
            keys_q    <= keys_d;
        end
    end

    // Both pads drive both players
    assign joy        = joystick_0 | joystick_1;
    assign unused_joy = ^joy[15:7];

    // Merge keys with the pad, remap for orientation and pack active-low
    always_comb begin
        raw_1p.up    = keys_q[K_UP]    | joy[JOY_UP];
        raw_1p.down  = keys_q[K_DOWN]  | joy[JOY_DOWN];
        raw_1p.left  = keys_q[K_LEFT]  | joy[JOY_LEFT];
        raw_1p.right = keys_q[K_RIGHT] | joy[JOY_RIGHT];

        raw_2p.up    = keys_q[K_P2_UP]    | joy[JOY_UP];
        raw_2p.down  = keys_q[K_P2_DOWN]  | joy[JOY_DOWN];
        raw_2p.left  = keys_q[K_P2_LEFT]  | joy[JOY_LEFT];
        raw_2p.right = keys_q[K_P2_RIGHT] | joy[JOY_RIGHT];

        dir_1p = orient(raw_1p, rotate);
        dir_2p = orient(raw_2p, rotate);

        fire_1p  = keys_q[K_FIRE_A] | keys_q[K_FIRE_B] | joy[JOY_FIRE];
        fire_2p  = keys_q[K_P2_FIRE] | joy[JOY_FIRE];
        start_1p = keys_q[K_START1_A] | keys_q[K_START1_B] | joy[JOY_START1];
        start_2p = keys_q[K_START2_A] | keys_q[K_START2_B] | joy[JOY_START2];

        ip_1p_d = ~{start_1p, fire_1p, fire_1p, dir_1p.left, dir_1p.right,
                    dir_1p.up, dir_1p.down};
        ip_2p_d = ~{start_2p, fire_2p, fire_2p, dir_2p.left, dir_2p.right,
                    dir_2p.up, dir_2p.down};
    end

    // Registered player inputs and test button
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            ip_1p_q    <= 7'h7F;
            ip_2p_q    <= 7'h7F;
            btn_test_q <= 1'b0;
        end else begin
            ip_1p_q    <= ip_1p_d;
            ip_2p_q    <= ip_2p_d;
            btn_test_q <= keys_q[K_TEST];
        end
    end

    assign ip_1p    = ip_1p_q;
    assign ip_2p    = ip_2p_q;
    assign btn_test = btn_test_q;

    // Pad start buttons double as coin 1 so a pad-only setup can credit
    assign req1 = keys_q[K_COIN1] | joy[JOY_START1] | joy[JOY_START2];
    assign req2 = keys_q[K_COIN2];

    coin_pulse #(
        .PULSE_CYCLES(COIN_PULSE_CYCLES),
        .GAP_CYCLES  (COIN_GAP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_coin1 (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .req    (req1),
        .pulse  (ip_coin1)
    );

    coin_pulse #(
        .PULSE_CYCLES(COIN_PULSE_CYCLES),
        .GAP_CYCLES  (COIN_GAP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_coin2 (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .req    (req2),
        .pulse  (ip_coin2)
    );

endmodule
